// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: FSM state encoding and default bus widths
// used by the fetch unit, the control unit and the PC logic.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W   = 8;
  localparam int unsigned FETCH_DATA_W   = 16;
  localparam int unsigned FETCH_DEPTH    = 2;
  localparam int unsigned FETCH_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instruction} with push, pop and
// flush. The head is kept in output registers so it holds its last value
// when the buffer drains. DEPTH must be a power of two so pointers wrap.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = FETCH_DEPTH,
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic              full_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [DATA_W-1:0] head_data_o
);

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, full_q;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              do_push, do_pop;

  // Pointer/occupancy update and next head selection; flush wins over push/pop.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head_pc_d   = head_pc_q;
    head_data_d = head_data_q;
    do_pop      = pop_i && valid_q && !flush_i;
    do_push     = push_i && !flush_i && (!full_q || do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
      if (count_d != '0) begin
        if (do_push && count_d == CNT_W'(1)) begin
          head_pc_d   = push_pc_i;
          head_data_d = push_data_i;
        end else begin
          head_pc_d   = pc_mem_q[rd_ptr_d];
          head_data_d = data_mem_q[rd_ptr_d];
        end
      end
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      full_q      <= 1'b0;
      head_pc_q   <= '0;
      head_data_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      valid_q     <= (count_d != '0);
      full_q      <= (count_d == CNT_W'(DEPTH));
      head_pc_q   <= head_pc_d;
      head_data_q <= head_data_d;
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (do_push) begin
      pc_mem_q[wr_ptr_q]   <= push_pc_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o     = valid_q;
  assign full_o      = full_q;
  assign count_o     = count_q;
  assign head_pc_o   = head_pc_q;
  assign head_data_o = head_data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential fetch from instruction memory with one
// outstanding request, buffering into fetch_fifo for the decode stage.
// Optional feature macro FETCH_REDIRECT_EN adds redirect_valid/redirect_pc to
// flush the buffer and restart fetching at a new address.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       DATA_W   = FETCH_DATA_W,
  parameter int unsigned       DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc
`ifdef FETCH_REDIRECT_EN
  ,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              discard_q, discard_d;
  logic              redir;
  logic [ADDR_W-1:0] redir_pc;
  logic              transfer, pop, fifo_push;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;

`ifdef FETCH_REDIRECT_EN
  assign redir    = redirect_valid;
  assign redir_pc = redirect_pc;
`else
  assign redir    = 1'b0;
  assign redir_pc = '0;
`endif

  // Next state, fetch address and buffer control.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    transfer   = mem_req_q && mem_ack;
    pop        = ins_valid && ins_ready && !redir;
    fifo_push  = 1'b0;

    if (transfer) begin
      if (discard_q) begin
        // Word belongs to the pre-redirect stream; pc already points at the target.
        discard_d = 1'b0;
      end else if (!redir && (!fifo_full || pop)) begin
        fifo_push = 1'b1;
        pc_d      = pc_q + ADDR_W'(1);
      end
    end

    if (redir) begin
      pc_d = redir_pc;
      if (mem_req_q && !mem_ack) discard_d = 1'b1;
    end

    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (!redir && fifo_push && !pop && fifo_count == CNT_W'(DEPTH - 1))
          state_d = HOLD;
      end
      HOLD:  if (redir || pop) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    mem_req_d  = (state_d == FETCH);
    // Address stays frozen while a request is still waiting for its ack.
    mem_addr_d = (mem_req_q && !mem_ack) ? mem_addr_q : pc_d;
  end

  // FSM and fetch-address registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (fifo_push),
    .push_pc_i   (mem_addr_q),
    .push_data_i (mem_rdata),
    .pop_i       (pop),
    .flush_i     (redir),
    .valid_o     (ins_valid),
    .full_o      (fifo_full),
    .count_o     (fifo_count),
    .head_pc_o   (ins_pc),
    .head_data_o (ins_data)
  );

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected addresses and
// instruction pcs; a negedge monitor compares every memory transfer and every
// instruction handoff against them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_ack, ins_valid, ins_ready;
  logic [7:0]  mem_addr, ins_pc;
  logic [15:0] mem_rdata, ins_data;
  logic        mem_req2, mem_ack2, ins_valid2, ins_ready2;
  logic [7:0]  mem_addr2, ins_pc2;
  logic [15:0] mem_rdata2, ins_data2;
`ifdef FETCH_REDIRECT_EN
  logic        redirect_valid, redirect_valid2;
  logic [7:0]  redirect_pc, redirect_pc2;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_addr[$], exp_ins[$], exp_addr2[$], exp_ins2[$];

  always #5 clk = ~clk;

  // Memory model: word at address a is {8'hD0, a}.
  assign mem_rdata  = {8'hD0, mem_addr};
  assign mem_rdata2 = {8'hD0, mem_addr2};

  fetch_unit #(.ADDR_W(8), .DATA_W(16), .DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .ins_data(ins_data), .ins_pc(ins_pc)
`ifdef FETCH_REDIRECT_EN
    , .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`endif
  );

  fetch_unit #(.ADDR_W(8), .DATA_W(16), .DEPTH(2), .RESET_PC(8'hFE)) dut2 (
    .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata2), .ins_valid(ins_valid2),
    .ins_ready(ins_ready2), .ins_data(ins_data2), .ins_pc(ins_pc2)
`ifdef FETCH_REDIRECT_EN
    , .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drained(input string nm);
    chk({nm, "_addr_left"}, exp_addr.size(), 0);
    chk({nm, "_ins_left"},  exp_ins.size(),  0);
    exp_addr.delete();
    exp_ins.delete();
  endtask

  task automatic reset_hold();
    reset = 1'b0; mem_ack = 1'b0; ins_ready = 1'b0; mem_ack2 = 1'b0;
    step(2);
  endtask

  // Monitor: compare each transfer and each instruction handoff with the queues.
  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      if (exp_addr.size() == 0) begin
        n_checks++;
        $display("FAIL addr_unexpected: got %0h expected none", mem_addr);
      end else chk("mem_addr", mem_addr, exp_addr.pop_front());
    end
    if (ins_valid && ins_ready) begin
      if (exp_ins.size() == 0) begin
        n_checks++;
        $display("FAIL ins_unexpected: got pc %0h expected none", ins_pc);
      end else begin
        logic [7:0] e;
        e = exp_ins.pop_front();
        chk("ins_pc", ins_pc, e);
        chk("ins_data", ins_data, {8'hD0, e});
      end
    end
    if (mem_req2 && mem_ack2) begin
      if (exp_addr2.size() == 0) begin
        n_checks++;
        $display("FAIL addr2_unexpected: got %0h expected none", mem_addr2);
      end else chk("mem_addr2", mem_addr2, exp_addr2.pop_front());
    end
    if (ins_valid2 && ins_ready2) begin
      if (exp_ins2.size() == 0) begin
        n_checks++;
        $display("FAIL ins2_unexpected: got pc %0h expected none", ins_pc2);
      end else begin
        logic [7:0] e;
        e = exp_ins2.pop_front();
        chk("ins_pc2", ins_pc2, e);
        chk("ins_data2", ins_data2, {8'hD0, e});
      end
    end
  end

  initial begin
    reset = 1'b0; mem_ack = 1'b0; ins_ready = 1'b0;
    mem_ack2 = 1'b0; ins_ready2 = 1'b1;
`ifdef FETCH_REDIRECT_EN
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    redirect_valid2 = 1'b0; redirect_pc2 = 8'h00;
`endif
    step(2);
    chk("rst_mem_req",   mem_req,   0);
    chk("rst_mem_addr",  mem_addr,  8'h00);
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_ins_data",  ins_data,  16'h0000);
    chk("rst_ins_pc",    ins_pc,    8'h00);
    chk("rst2_mem_addr", mem_addr2, 8'hFE);

    // Streaming: ack and ready high, one instruction per cycle.
    mem_ack = 1'b1; ins_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(8'(i));
      exp_ins.push_back(8'(i));
    end
    reset = 1'b1;
    step(9);
    mem_ack = 1'b0;
    step(1);
    chk("stream_empty_valid", ins_valid, 0);
    chk("stream_hold_pc",     ins_pc,    8'h07);
    chk("stream_hold_data",   ins_data,  16'hD007);
    chk("stream_next_req",    mem_req,   1);
    chk("stream_next_addr",   mem_addr,  8'h08);
    drained("stream");

    // Backpressure: buffer fills, HOLD, one pop restarts at addr 2.
    reset_hold();
    mem_ack = 1'b1; ins_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(8'(i));
      exp_ins.push_back(8'(i));
    end
    reset = 1'b1;
    step(3);
    chk("hold_req_c3", mem_req, 0);
    step(1);
    chk("hold_req_c4",   mem_req,   0);
    chk("hold_valid_c4", ins_valid, 1);
    chk("hold_pc_c4",    ins_pc,    8'h00);
    step(1);
    ins_ready = 1'b1;
    step(1);
    ins_ready = 1'b0;
    chk("resume_req",  mem_req,  1);
    chk("resume_addr", mem_addr, 8'h02);
    step(1);
    chk("rehold_req", mem_req, 0);
    mem_ack = 1'b0;
    step(1);
    ins_ready = 1'b1;
    step(2);
    chk("hold_drain_valid", ins_valid, 0);
    drained("hold");

    // Slow memory: ack withheld three cycles at addr 5.
    reset_hold();
    mem_ack = 1'b1; ins_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_addr.push_back(8'(i));
      exp_ins.push_back(8'(i));
    end
    reset = 1'b1;
    step(6);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("wait_req",  mem_req,  1);
      chk("wait_addr", mem_addr, 8'h05);
      step(1);
    end
    chk("wait_empty_valid", ins_valid, 0);
    chk("wait_hold_pc",     ins_pc,    8'h04);
    mem_ack = 1'b1;
    step(1);
    mem_ack = 1'b0;
    chk("wait_next_addr", mem_addr, 8'h06);
    step(1);
    chk("wait_drain_valid", ins_valid, 0);
    drained("wait");

    // Address wrap on the instance starting at 0xFE.
    reset_hold();
    mem_ack2 = 1'b1;
    exp_addr2.push_back(8'hFE); exp_addr2.push_back(8'hFF);
    exp_addr2.push_back(8'h00); exp_addr2.push_back(8'h01);
    exp_ins2.push_back(8'hFE);  exp_ins2.push_back(8'hFF);
    exp_ins2.push_back(8'h00);  exp_ins2.push_back(8'h01);
    reset = 1'b1;
    step(5);
    mem_ack2 = 1'b0;
    step(1);
    chk("wrap_valid",     ins_valid2, 0);
    chk("wrap_next_addr", mem_addr2,  8'h02);
    chk("wrap_addr_left", exp_addr2.size(), 0);
    chk("wrap_ins_left",  exp_ins2.size(),  0);

    // Reset mid-request with one buffered entry; stray ack afterwards ignored.
    reset_hold();
    mem_ack = 1'b1; ins_ready = 1'b0;
    exp_addr.push_back(8'h00);
    reset = 1'b1;
    step(2);
    mem_ack = 1'b0;
    chk("pre_rst_valid", ins_valid, 1);
    chk("pre_rst_addr",  mem_addr,  8'h01);
    step(1);
    reset = 1'b0;
    #1;
    chk("async_rst_req",   mem_req,   0);
    chk("async_rst_valid", ins_valid, 0);
    chk("async_rst_data",  ins_data,  16'h0000);
    chk("async_rst_pc",    ins_pc,    8'h00);
    chk("async_rst_addr",  mem_addr,  8'h00);
    step(1);
    mem_ack = 1'b1;
    reset = 1'b1;
    step(1);
    mem_ack = 1'b0;
    chk("post_rst_req",  mem_req,  1);
    chk("post_rst_addr", mem_addr, 8'h00);
    step(1);
    chk("stray_ack_valid", ins_valid, 0);
    drained("rst");

`ifdef FETCH_REDIRECT_EN
    // Redirect to 0x40 while the request at 0x07 is pending.
    reset_hold();
    mem_ack = 1'b1; ins_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_addr.push_back(8'(i));
    exp_addr.push_back(8'h40);
    for (int i = 0; i < 6; i++) exp_ins.push_back(8'(i));
    exp_ins.push_back(8'h40);
    reset = 1'b1;
    step(8);
    mem_ack = 1'b0; ins_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    step(1);
    redirect_valid = 1'b0; ins_ready = 1'b1;
    chk("redir_old_req",   mem_req,   1);
    chk("redir_old_addr",  mem_addr,  8'h07);
    chk("redir_flush",     ins_valid, 0);
    step(1);
    mem_ack = 1'b1;
    step(1);
    chk("redir_new_addr",  mem_addr,  8'h40);
    chk("redir_new_req",   mem_req,   1);
    chk("redir_discard",   ins_valid, 0);
    step(1);
    mem_ack = 1'b0;
    step(1);
    drained("redir");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
